mac_accumulator: RTL and testbench

- Downstream stage of the Booth multiplier: consumes the multiplier's one-cycle `valid` pulse and its 8-bit signed product, then sums a programmed number of products into a wider signed accumulator.
- Completes the multiply-accumulate path. One run = `len` products, ended by a `done` pulse, with `acc_out` held until the next run starts.
- Saturating arithmetic with a sticky overflow flag.

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_accumulator_if.sv | 29 ++
 rtl/sat_adder.sv | 33 +++
 rtl/mac_accumulator.sv | 79 +++++++
 tb/tb_mac_accumulator.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate path: FSM encoding and default widths.
package mac_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } mac_state_e;

  localparam int unsigned ProdWDefault = 8;
  localparam int unsigned AccWDefault  = 20;
  localparam int unsigned LenWDefault  = 4;

endpackage

// File: rtl/mac_accumulator_if.sv
// Run-control and product bus between the multiplier-side driver and mac_accumulator.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = ProdWDefault,
  parameter int unsigned ACC_W  = AccWDefault,
  parameter int unsigned LEN_W  = LenWDefault
) ();

  logic                     start;
  logic [LEN_W-1:0]         len;
  logic                     prod_valid;
  logic signed [PROD_W-1:0] prod;
  logic                     busy;
  logic signed [ACC_W-1:0]  acc_out;
  logic                     done;
  logic                     overflow;

  modport master (
    output start, len, prod_valid, prod,
    input  busy, acc_out, done, overflow
  );

  modport slave (
    input  start, len, prod_valid, prod,
    output busy, acc_out, done, overflow
  );

endinterface

// File: rtl/sat_adder.sv
// Combinational saturating add of a sign-extended product into a signed accumulator.
module sat_adder #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic signed [PROD_W-1:0] prod_i,
  output logic signed [ACC_W-1:0]  sum_o,
  output logic                     sat_flag_o
);

  logic [ACC_W:0] wide;
  logic           pos_ovf;
  logic           neg_ovf;

  // One guard bit is enough: both operands fit in ACC_W signed bits.
  assign wide    = {acc_i[ACC_W-1], acc_i}
                 + {{(ACC_W + 1 - PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign pos_ovf = ~wide[ACC_W] & wide[ACC_W-1];
  assign neg_ovf = wide[ACC_W] & ~wide[ACC_W-1];

  always_comb begin
    sum_o = wide[ACC_W-1:0];
    if (pos_ovf) begin
      sum_o = {1'b0, {(ACC_W - 1){1'b1}}};
    end else if (neg_ovf) begin
      sum_o = {1'b1, {(ACC_W - 1){1'b0}}};
    end
  end

  assign sat_flag_o = pos_ovf | neg_ovf;

endmodule

// File: rtl/mac_accumulator.sv
// Sums a programmed number of signed products with saturation; pulses done when the run ends.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = ProdWDefault,
  parameter int unsigned ACC_W  = AccWDefault,
  parameter int unsigned LEN_W  = LenWDefault
) (
  input logic              clk,
  input logic              rst,
  mac_accumulator_if.slave bus
);

  mac_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] sum;
  logic                    sat;

  sat_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_adder (
    .acc_i      (acc_q),
    .prod_i     (bus.prod),
    .sum_o      (sum),
    .sat_flag_o (sat)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = bus.len;
          state_d = (bus.len != '0) ? StAccum : StDone;
        end
      end
      StAccum: begin
        if (bus.prod_valid) begin
          acc_d = sum;
          ovf_d = ovf_q | sat;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.acc_out  = acc_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: runs push expected results, a monitor checks each done.
module tb_mac_accumulator;

  localparam int unsigned PW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned LW = 4;
  localparam int AccMax = (1 << (AW - 1)) - 1;
  localparam int AccMin = -(1 << (AW - 1));

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];
  int   stim_q[$];

  mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) bus ();

  mac_accumulator #(
    .PROD_W (PW),
    .ACC_W  (AW),
    .LEN_W  (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: plain integer running sum, clamped after every addition.
  function automatic exp_t model(input int prods[$]);
    exp_t e;
    e.acc = 0;
    e.ovf = 1'b0;
    foreach (prods[i]) begin
      e.acc = e.acc + prods[i];
      if (e.acc > AccMax) begin e.acc = AccMax; e.ovf = 1'b1; end
      if (e.acc < AccMin) begin e.acc = AccMin; e.ovf = 1'b1; end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_acc_out", int'($signed(bus.acc_out)), e.acc);
        chk("sb_overflow", int'(bus.overflow), int'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs stim_q through the DUT. gap range spaces the pulses; inj_at injects a start
  // while busy before that product; dirty_done drives start/prod_valid in the DONE cycle.
  task automatic run(input int gap_lo, input int gap_hi, input bit pv_with_start,
                     input int inj_at, input bit dirty_done,
                     input int chk_from, input int chk_val);
    exp_t e;
    int   n;
    n = stim_q.size();
    e = model(stim_q);
    exp_q.push_back(e);
    bus.start      = 1'b1;
    bus.len        = LW'(n);
    bus.prod_valid = pv_with_start;
    bus.prod       = 8'sd50;
    tick();
    bus.start      = 1'b0;
    bus.prod_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) tick();
      if (i == inj_at) begin
        bus.start = 1'b1;
        bus.len   = 4'd1;
        tick();
        bus.start = 1'b0;
      end
      bus.prod_valid = 1'b1;
      bus.prod       = PW'(stim_q[i]);
      tick();
      bus.prod_valid = 1'b0;
      if (chk_from > 0 && i + 1 >= chk_from) chk("mid_acc", int'($signed(bus.acc_out)), chk_val);
    end
    chk("done_high", int'(bus.done), 1);
    chk("acc_at_done", int'($signed(bus.acc_out)), e.acc);
    if (dirty_done) begin
      bus.start      = 1'b1;
      bus.len        = 4'd3;
      bus.prod_valid = 1'b1;
      bus.prod       = 8'sd77;
    end
    tick();
    bus.start      = 1'b0;
    bus.prod_valid = 1'b0;
    chk("done_low_after", int'(bus.done), 0);
    chk("busy_low_after", int'(bus.busy), 0);
    chk("acc_held_idle", int'($signed(bus.acc_out)), e.acc);
    stim_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.len        = '0;
    bus.prod_valid = 1'b0;
    bus.prod       = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_acc", int'($signed(bus.acc_out)), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ovf", int'(bus.overflow), 0);

    // Products in IDLE before any start must be ignored.
    repeat (3) begin
      bus.prod_valid = 1'b1;
      bus.prod       = 8'sd100;
      tick();
    end
    bus.prod_valid = 1'b0;
    chk("idle_pv_ignored", int'($signed(bus.acc_out)), 0);
    chk("idle_pv_busy", int'(bus.busy), 0);

    stim_q = '{5, -3, 7};
    run(9, 9, 1'b0, -1, 1'b0, 0, 0);

    stim_q.delete();
    run(0, 0, 1'b1, -1, 1'b0, 0, 0);

    repeat (15) stim_q.push_back(127);
    run(0, 1, 1'b0, -1, 1'b0, 5, AccMax);
    repeat (15) stim_q.push_back(-128);
    run(0, 1, 1'b0, -1, 1'b0, 5, AccMin);

    stim_q = '{11, -20, 33, 4};
    run(1, 2, 1'b0, 2, 1'b0, 0, 0);

    // Abort mid-run: no expectation queued, so any done pulse is flagged.
    bus.start = 1'b1;
    bus.len   = 4'd5;
    tick();
    bus.start = 1'b0;
    repeat (2) begin
      bus.prod_valid = 1'b1;
      bus.prod       = 8'sd60;
      tick();
      bus.prod_valid = 1'b0;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_acc", int'($signed(bus.acc_out)), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_ovf", int'(bus.overflow), 0);
    repeat (6) begin
      bus.prod_valid = 1'b1;
      tick();
    end
    bus.prod_valid = 1'b0;
    stim_q = '{-1};
    run(0, 0, 1'b0, -1, 1'b0, 0, 0);

    stim_q = '{9, 9};
    run(0, 0, 1'b0, -1, 1'b1, 0, 0);
    stim_q = '{100, 100};
    run(0, 3, 1'b0, -1, 1'b0, 0, 0);

    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(15, 0);
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        stim_q.push_back(int'($signed(b)));
      end
      run(0, 2, r[0], -1, r[1], 0, 0);
    end

    repeat (3) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
